// File: rtl/ctrl_pkg.sv
// Shared types for the control sequencer: state codes, opcodes and ALU selects.
// The JPZ state exists only when CTRL_JPZ_EN is defined.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_NOOP   = 4'd3,
    ST_LOAD_A = 4'd4,
    ST_LOAD_B = 4'd5,
    ST_STORE  = 4'd6,
    ST_ADD    = 4'd7,
    ST_SUB    = 4'd8,
`ifdef CTRL_JPZ_EN
    ST_JPZ    = 4'd9,
`endif
    ST_HALT   = 4'd10
  } state_e;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5,
    OP_JPZ   = 4'd6
  } opcode_e;

  localparam logic [2:0] ALU_PASS_A = 3'd0;
  localparam logic [2:0] ALU_ADD    = 3'd1;
  localparam logic [2:0] ALU_SUB    = 3'd2;

endpackage

// File: rtl/instr_reg.sv
// 16-bit instruction register with synchronous clear and load enable.
// Exposes the opcode and the operand fields used by the sequencer.
module instr_reg
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        ld_i,
  input  logic [15:0] d_i,
  output opcode_e     op_o,
  output logic [3:0]  ra_o,
  output logic [3:0]  rb_o,
  output logic [3:0]  w_o,
  output logic [7:0]  imm_o,
  output logic [7:0]  laddr_o
);

  logic [15:0] ir_q;
  logic [15:0] ir_d;

  always_comb begin
    ir_d = ld_i ? d_i : ir_q;
  end

  always_ff @(posedge clk) begin
    if (clr) ir_q <= '0;
    else     ir_q <= ir_d;
  end

  assign op_o    = opcode_e'(ir_q[15:12]);
  assign ra_o    = ir_q[11:8];
  assign rb_o    = ir_q[7:4];
  assign w_o     = ir_q[3:0];
  assign imm_o   = ir_q[7:0];
  assign laddr_o = ir_q[11:4];

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode and per-opcode execute states.
// Define CTRL_JPZ_EN to add the conditional relative jump (opcode 0110).
//
// state   | meaning
// INIT    | PC cleared, waiting for reset release
// FETCH   | IR <= im_q, PC advances by one
// DECODE  | pick execute state from IR[15:12]
// NOOP    | no operation
// LOAD_A  | present data-memory address IR[11:4]
// LOAD_B  | write memory data into register IR[3:0]
// STORE   | write register IR[11:8] to memory IR[7:0]
// ADD/SUB | IR[3:0] <= IR[11:8] +/- IR[7:4]
// JPZ     | branch by IR[7:0] when register IR[11:8] is zero
// HALT    | parked until clr
module control_sequencer
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic [15:0]       im_q,
  input  logic              ra_zero,
  output logic              pc_clr,
  output logic signed [7:0] pc_up,
  output logic [7:0]        d_addr,
  output logic              d_wr,
  output logic              rf_s,
  output logic [3:0]        rf_w_addr,
  output logic              rf_w_wr,
  output logic [3:0]        rf_ra_addr,
  output logic              rf_ra_rd,
  output logic [3:0]        rf_rb_addr,
  output logic              rf_rb_rd,
  output logic [2:0]        alu_s,
  output logic [3:0]        state,
  output logic              halted
);

  state_e     state_q;
  state_e     state_d;
  opcode_e    op;
  logic [3:0] f_ra;
  logic [3:0] f_rb;
  logic [3:0] f_w;
  logic [7:0] f_imm;
  logic [7:0] f_laddr;
  logic       ir_ld;

  assign ir_ld = (state_q == ST_FETCH);

  instr_reg u_ir (
    .clk     (clk),
    .clr     (clr),
    .ld_i    (ir_ld),
    .d_i     (im_q),
    .op_o    (op),
    .ra_o    (f_ra),
    .rb_o    (f_rb),
    .w_o     (f_w),
    .imm_o   (f_imm),
    .laddr_o (f_laddr)
  );

`ifndef CTRL_JPZ_EN
  logic unused_ra_zero;
  assign unused_ra_zero = ra_zero;
`endif

  always_ff @(posedge clk) begin
    if (clr) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_clr     = 1'b0;
    pc_up      = 8'sd0;
    d_addr     = 8'd0;
    d_wr       = 1'b0;
    rf_s       = 1'b0;
    rf_w_addr  = 4'd0;
    rf_w_wr    = 1'b0;
    rf_ra_addr = 4'd0;
    rf_ra_rd   = 1'b0;
    rf_rb_addr = 4'd0;
    rf_rb_rd   = 1'b0;
    alu_s      = ALU_PASS_A;
    halted     = 1'b0;

    case (state_q)
      ST_INIT: begin
        pc_clr  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        pc_up   = 8'sd1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (op)
          OP_STORE: state_d = ST_STORE;
          OP_LOAD:  state_d = ST_LOAD_A;
          OP_ADD:   state_d = ST_ADD;
          OP_SUB:   state_d = ST_SUB;
          OP_HALT:  state_d = ST_HALT;
`ifdef CTRL_JPZ_EN
          OP_JPZ:   state_d = ST_JPZ;
`endif
          default:  state_d = ST_NOOP;
        endcase
      end
      ST_NOOP: state_d = ST_FETCH;
      ST_LOAD_A: begin
        d_addr  = f_laddr;
        state_d = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        d_addr    = f_laddr;
        rf_s      = 1'b1;
        rf_w_addr = f_w;
        rf_w_wr   = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_STORE: begin
        d_addr     = f_imm;
        rf_ra_addr = f_ra;
        rf_ra_rd   = 1'b1;
        alu_s      = ALU_PASS_A;
        d_wr       = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_ADD, ST_SUB: begin
        rf_ra_addr = f_ra;
        rf_ra_rd   = 1'b1;
        rf_rb_addr = f_rb;
        rf_rb_rd   = 1'b1;
        rf_w_addr  = f_w;
        rf_w_wr    = 1'b1;
        alu_s      = (state_q == ST_ADD) ? ALU_ADD : ALU_SUB;
        state_d    = ST_FETCH;
      end
`ifdef CTRL_JPZ_EN
      ST_JPZ: begin
        rf_ra_addr = f_ra;
        rf_ra_rd   = 1'b1;
        // PC already advanced past the jump in FETCH, hence the -1
        pc_up      = ra_zero ? $signed(f_imm - 8'd1) : 8'sd0;
        state_d    = ST_FETCH;
      end
`endif
      ST_HALT: halted = 1'b1;
      default: state_d = ST_INIT;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus random
// instruction streams checked against a phase-list reference model.
module tb_control_sequencer;
  import ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              clr;
  logic [15:0]       im_q;
  logic              ra_zero;
  logic              pc_clr;
  logic signed [7:0] pc_up;
  logic [7:0]        d_addr;
  logic              d_wr;
  logic              rf_s;
  logic [3:0]        rf_w_addr;
  logic              rf_w_wr;
  logic [3:0]        rf_ra_addr;
  logic              rf_ra_rd;
  logic [3:0]        rf_rb_addr;
  logic              rf_rb_rd;
  logic [2:0]        alu_s;
  logic [3:0]        state;
  logic              halted;

  int checks   = 0;
  int failures = 0;

  control_sequencer dut (
    .clk(clk), .clr(clr), .im_q(im_q), .ra_zero(ra_zero),
    .pc_clr(pc_clr), .pc_up(pc_up), .d_addr(d_addr), .d_wr(d_wr),
    .rf_s(rf_s), .rf_w_addr(rf_w_addr), .rf_w_wr(rf_w_wr),
    .rf_ra_addr(rf_ra_addr), .rf_ra_rd(rf_ra_rd),
    .rf_rb_addr(rf_rb_addr), .rf_rb_rd(rf_rb_rd),
    .alu_s(alu_s), .state(state), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef enum int {P_INIT, P_FETCH, P_DECODE, P_NOOP, P_LOADA, P_LOADB,
                    P_STORE, P_ADD, P_SUB, P_JPZ, P_HALT} phase_e;
  typedef phase_e phase_q_t[$];

  // Cycle-by-cycle phases an instruction passes through, starting at FETCH
  function automatic phase_q_t phases_of(logic [15:0] ir);
    phase_q_t q;
    q.push_back(P_FETCH);
    q.push_back(P_DECODE);
    case (ir[15:12])
      4'h1: q.push_back(P_STORE);
      4'h2: begin q.push_back(P_LOADA); q.push_back(P_LOADB); end
      4'h3: q.push_back(P_ADD);
      4'h4: q.push_back(P_SUB);
      4'h5: q.push_back(P_HALT);
`ifdef CTRL_JPZ_EN
      4'h6: q.push_back(P_JPZ);
`endif
      default: q.push_back(P_NOOP);
    endcase
    return q;
  endfunction

  function automatic logic [3:0] st_of(phase_e p);
    case (p)
      P_INIT:   return ST_INIT;
      P_FETCH:  return ST_FETCH;
      P_DECODE: return ST_DECODE;
      P_NOOP:   return ST_NOOP;
      P_LOADA:  return ST_LOAD_A;
      P_LOADB:  return ST_LOAD_B;
      P_STORE:  return ST_STORE;
      P_ADD:    return ST_ADD;
      P_SUB:    return ST_SUB;
`ifdef CTRL_JPZ_EN
      P_JPZ:    return ST_JPZ;
`endif
      P_HALT:   return ST_HALT;
      default:  return 4'hF;
    endcase
  endfunction

  // Expected outputs packed {pc_clr,pc_up,d_addr,d_wr,rf_s,w_addr,w_wr,ra,ra_rd,rb,rb_rd,alu_s,state,halted}
  function automatic logic [41:0] exp_vec(phase_e p, logic [15:0] ir, logic raz);
    logic       e_clr = 0, e_dwr = 0, e_s = 0, e_wwr = 0, e_rard = 0, e_rbrd = 0, e_halt = 0;
    logic [7:0] e_up = 0, e_da = 0;
    logic [3:0] e_w = 0, e_ra = 0, e_rb = 0;
    logic [2:0] e_alu = 0;
    case (p)
      P_INIT:  e_clr = 1;
      P_FETCH: e_up = 8'd1;
      P_LOADA: e_da = ir[11:4];
      P_LOADB: begin e_da = ir[11:4]; e_s = 1; e_w = ir[3:0]; e_wwr = 1; end
      P_STORE: begin e_da = ir[7:0]; e_ra = ir[11:8]; e_rard = 1; e_dwr = 1; end
      P_ADD, P_SUB: begin
        e_ra = ir[11:8]; e_rard = 1; e_rb = ir[7:4]; e_rbrd = 1;
        e_w = ir[3:0]; e_wwr = 1; e_alu = (p == P_ADD) ? 3'd1 : 3'd2;
      end
      P_JPZ: begin e_ra = ir[11:8]; e_rard = 1; e_up = raz ? ir[7:0] + 8'hFF : 8'd0; end
      P_HALT: e_halt = 1;
      default: ;
    endcase
    return {e_clr, e_up, e_da, e_dwr, e_s, e_w, e_wwr, e_ra, e_rard, e_rb, e_rbrd,
            e_alu, st_of(p), e_halt};
  endfunction

  function automatic logic [41:0] act_vec();
    return {pc_clr, pc_up, d_addr, d_wr, rf_s, rf_w_addr, rf_w_wr, rf_ra_addr, rf_ra_rd,
            rf_rb_addr, rf_rb_rd, alu_s, state, halted};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present an instruction during FETCH; leaves the DUT in DECODE with junk on im_q
  task automatic fetch(logic [15:0] ir, logic raz);
    im_q    = ir;
    ra_zero = raz;
    tick();
    im_q = 16'($urandom);
  endtask

  task automatic test_reset();
    clr = 1; im_q = 16'($urandom); ra_zero = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (act_vec() !== {1'b1, 41'd0}) begin
        failures++;
        $display("FAIL reset_hold cyc%0d: got %h expected %h", i, act_vec(), {1'b1, 41'd0});
      end
    end
    clr = 0;
    tick();
    checks++;
    if (state !== ST_FETCH || pc_up !== 8'sd1 || pc_clr !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: state=%0d pc_up=%0d pc_clr=%0b expected state=%0d pc_up=1 pc_clr=0",
               state, pc_up, pc_clr, ST_FETCH);
    end
  endtask

  task automatic test_add();
    fetch(16'h3124, 0);
    checks++;
    if (state !== ST_DECODE) begin
      failures++; $display("FAIL add_decode: state=%0d expected %0d", state, ST_DECODE);
    end
    tick();
    checks++;
    if ({state, rf_ra_addr, rf_ra_rd, rf_rb_addr, rf_rb_rd, rf_w_addr, rf_w_wr, rf_s, alu_s, d_wr}
        !== {ST_ADD, 4'd1, 1'b1, 4'd2, 1'b1, 4'd4, 1'b1, 1'b0, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL add_exec: state=%0d ra=%0d rb=%0d w=%0d wwr=%0b alu=%0d dwr=%0b expected state=%0d ra=1 rb=2 w=4 wwr=1 alu=1 dwr=0",
               state, rf_ra_addr, rf_rb_addr, rf_w_addr, rf_w_wr, alu_s, d_wr, ST_ADD);
    end
    tick();
    checks++;
    if (state !== ST_FETCH) begin
      failures++; $display("FAIL add_return: state=%0d expected %0d", state, ST_FETCH);
    end
  endtask

  task automatic test_load();
    fetch(16'h2A53, 1);
    tick();
    checks++;
    if ({state, d_addr, d_wr, rf_w_wr} !== {ST_LOAD_A, 8'hA5, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL load_a: state=%0d d_addr=%h d_wr=%0b wwr=%0b expected state=%0d d_addr=a5 d_wr=0 wwr=0",
               state, d_addr, d_wr, rf_w_wr, ST_LOAD_A);
    end
    tick();
    checks++;
    if ({state, d_addr, rf_s, rf_w_addr, rf_w_wr, d_wr} !== {ST_LOAD_B, 8'hA5, 1'b1, 4'd3, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL load_b: state=%0d d_addr=%h rf_s=%0b w=%0d wwr=%0b dwr=%0b expected state=%0d d_addr=a5 rf_s=1 w=3 wwr=1 dwr=0",
               state, d_addr, rf_s, rf_w_addr, rf_w_wr, d_wr, ST_LOAD_B);
    end
    tick();
    checks++;
    if (state !== ST_FETCH) begin
      failures++; $display("FAIL load_return: state=%0d expected %0d", state, ST_FETCH);
    end
  endtask

  task automatic test_store();
    fetch(16'h1780, 0);
    tick();
    checks++;
    if ({state, rf_ra_addr, rf_ra_rd, d_addr, d_wr, rf_w_wr, alu_s} !== {ST_STORE, 4'd7, 1'b1, 8'h80, 1'b1, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL store: state=%0d ra=%0d d_addr=%h d_wr=%0b wwr=%0b alu=%0d expected state=%0d ra=7 d_addr=80 d_wr=1 wwr=0 alu=0",
               state, rf_ra_addr, d_addr, d_wr, rf_w_wr, alu_s, ST_STORE);
    end
    tick();
  endtask

  task automatic test_jpz();
`ifdef CTRL_JPZ_EN
    fetch(16'h62FC, 1);
    tick();
    checks++;
    if ({state, pc_up, rf_ra_addr, rf_ra_rd} !== {ST_JPZ, 8'hFB, 4'd2, 1'b1}) begin
      failures++;
      $display("FAIL jpz_taken: state=%0d pc_up=%h ra=%0d rd=%0b expected state=%0d pc_up=fb ra=2 rd=1",
               state, pc_up, rf_ra_addr, rf_ra_rd, ST_JPZ);
    end
    tick();
    fetch(16'h62FC, 0);
    tick();
    checks++;
    if ({state, pc_up, rf_ra_rd} !== {ST_JPZ, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL jpz_not_taken: state=%0d pc_up=%h rd=%0b expected state=%0d pc_up=00 rd=1",
               state, pc_up, rf_ra_rd, ST_JPZ);
    end
    tick();
`else
    fetch(16'h62FC, 1);
    tick();
    checks++;
    if ({state, pc_up, rf_ra_rd} !== {ST_NOOP, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL jpz_disabled: state=%0d pc_up=%h rd=%0b expected state=%0d pc_up=00 rd=0",
               state, pc_up, rf_ra_rd, ST_NOOP);
    end
    tick();
`endif
    checks++;
    if (state !== ST_FETCH) begin
      failures++; $display("FAIL jpz_return: state=%0d expected %0d", state, ST_FETCH);
    end
  endtask

  task automatic test_halt();
    fetch(16'h5000, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      ra_zero = 1'($urandom);
      im_q    = 16'($urandom);
      checks++;
      if ({state, halted, pc_up, d_wr, rf_w_wr} !== {ST_HALT, 1'b1, 8'h00, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL halt_hold cyc%0d: state=%0d halted=%0b pc_up=%h dwr=%0b wwr=%0b expected state=%0d halted=1 pc_up=00 dwr=0 wwr=0",
                 i, state, halted, pc_up, d_wr, rf_w_wr, ST_HALT);
      end
      tick();
    end
    clr = 1;
    tick();
    checks++;
    if (act_vec() !== {1'b1, 41'd0}) begin
      failures++; $display("FAIL halt_clr: got %h expected %h", act_vec(), {1'b1, 41'd0});
    end
    clr = 0;
    tick();
  endtask

  task automatic test_clr_mid_load();
    fetch(16'h2A53, 0);
    tick();
    clr = 1;
    tick();
    checks++;
    if ({state, pc_clr, halted, d_wr, rf_w_wr} !== {ST_INIT, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL clr_mid_load: state=%0d pc_clr=%0b halted=%0b dwr=%0b wwr=%0b expected state=0 pc_clr=1 halted=0 dwr=0 wwr=0",
               state, pc_clr, halted, d_wr, rf_w_wr);
    end
    clr = 0;
    tick();
    checks++;
    if (state !== ST_FETCH) begin
      failures++; $display("FAIL clr_mid_load_release: state=%0d expected %0d", state, ST_FETCH);
    end
  endtask

  // Random non-halting instructions back to back, every cycle compared to the model
  task automatic test_random_stream();
    for (int n = 0; n < 200; n++) begin
      logic [15:0] ir;
      logic        raz;
      phase_q_t    ph;
      ir  = 16'($urandom);
      if (ir[15:12] == 4'h5) ir[15:12] = 4'h0;
      if (n % 4 == 0) ir[15:12] = 4'h6;
      raz = 1'($urandom);
      ph  = phases_of(ir);
      for (int k = 0; k < ph.size(); k++) begin
        if (k == 0) im_q = ir;
        ra_zero = (ph[k] == P_JPZ) ? raz : 1'($urandom);
        checks++;
        if (act_vec() !== exp_vec(ph[k], ir, ra_zero)) begin
          failures++;
          $display("FAIL rand_stream ir=%h phase=%0d: got %h expected %h",
                   ir, ph[k], act_vec(), exp_vec(ph[k], ir, ra_zero));
        end
        if (d_wr && rf_w_wr) begin
          failures++;
          $display("FAIL both_wr ir=%h: d_wr=1 rf_w_wr=1 expected not both", ir);
        end
        tick();
        if (k == 0) im_q = 16'($urandom);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_store();
    test_jpz();
    test_random_stream();
    test_clr_mid_load();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port clr, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port im_q, input, 16 bits: instruction-memory read data; valid one cycle after the PC address changes.
REQ-004 SHALL have port ra_zero, input, 1 bit: high when register-file read port A data equals zero.
REQ-005 SHALL have port pc_clr, output, 1 bit: drives the PC clear.
REQ-006 SHALL have port pc_up, output, signed 8 bits: drives the PC increment, which the PC adds every cycle.
REQ-007 SHALL have ports d_addr (output, 8 bits, data-memory address) and d_wr (output, 1 bit, data-memory write).
REQ-008 SHALL have ports rf_s (output, 1: write-data select, 1 = memory, 0 = ALU), rf_w_addr (output, 4), and rf_w_wr (output, 1).
REQ-009 SHALL have ports rf_ra_addr (output, 4), rf_ra_rd (output, 1), rf_rb_addr (output, 4), and rf_rb_rd (output, 1).
REQ-010 SHALL have ports alu_s (output, 3 bits: 0 = pass-A, 1 = add, 2 = sub), state (output, 4 bits: current state code) and halted (output, 1 bit).

Function
REQ-011 SHALL implement the states INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, JPZ and HALT.
REQ-012 SHALL sequence the states as follows:
- INIT->FETCH
- FETCH->DECODE
- DECODE->execute state chosen by IR[15:12]
- LOAD_A->LOAD_B
- every other execute state->FETCH
- HALT->HALT
REQ-013 SHALL decode opcodes as follows:
- 0000 NOOP
- 0001 STORE
- 0010 LOAD
- 0011 ADD
- 0100 SUB
- 0101 HALT
- 0110 JPZ
- 0111–1111 NOOP
REQ-014 SHALL have FETCH load the internal 16-bit IR from im_q and drive pc_up = +1.
REQ-015 SHALL drive pc_up = 0 in all states other than FETCH and a taken JPZ.
REQ-016 SHALL assert pc_clr in INIT only.
REQ-017 SHALL have STORE drive:
- d_addr = IR[7:0]
- rf_ra_addr = IR[11:8], rf_ra_rd = 1
- alu_s = 0
- d_wr = 1
REQ-018 SHALL have LOAD_A drive d_addr = IR[11:4] with d_wr = 0.
REQ-019 SHALL have LOAD_B hold d_addr = IR[11:4] and drive:
- rf_s = 1
- rf_w_addr = IR[3:0], rf_w_wr = 1
REQ-020 SHALL have ADD and SUB drive:
- rf_ra_addr = IR[11:8], rf_rb_addr = IR[7:4], both rd = 1
- rf_w_addr = IR[3:0], rf_w_wr = 1, rf_s = 0
- alu_s = 1 (ADD) or 2 (SUB)
REQ-021 SHALL have JPZ drive rf_ra_addr = IR[11:8] with rf_ra_rd = 1.
REQ-022 SHALL take the JPZ branch when ra_zero = 1, driving pc_up = IR[7:0] − 1 in 8-bit two's-complement wrap, so the target is jump-instruction address + IR[7:0].
REQ-023 SHALL drive pc_up = 0 in JPZ when ra_zero = 0.
REQ-024 SHALL hold HALT indefinitely with halted = 1, all write enables 0 and pc_up = 0, until clr.
REQ-025 SHALL hold every non-listed output at 0 in each state; d_wr and rf_w_wr SHALL never both be 1 in one cycle.
REQ-026 SHALL, for an instruction fetched at addr 127, wrap the PC to 0 via the PC's 7-bit truncation and apply no special handling.

Reset
REQ-027 SHALL, on clr = 1 at a rising edge, enter INIT and clear the IR to 0 on the next cycle, from any state including mid-LOAD and HALT.
REQ-028 SHALL hold in INIT every cycle while clr is held, with outputs pc_clr = 1, halted = 0 and all other outputs 0.
REQ-029 SHALL not make a write enable high in the cycle after a clr edge.

Configuration
REQ-030 SHALL, with macro CTRL_JPZ_EN defined, implement opcode 0110 as JPZ per REQ-021 to REQ-023.
REQ-031 SHALL, without CTRL_JPZ_EN, omit state JPZ entirely, decode 0110 as NOOP, and leave the ra_zero port present but ignored.

Structure
REQ-032 SHALL place the state enum (4-bit, INIT = 0), the opcode enum and the alu_s constants in shared package ctrl_pkg.
REQ-033 SHALL use one sub-module, instr_reg: a 16-bit register with synchronous clr and a load enable, with field-extract outputs.

Verification
REQ-034 SHALL verify reset: clr high 2 cycles then low -> state INIT with pc_clr = 1, then FETCH next cycle, pc_up = 1.
REQ-035 SHALL verify ADD: im_q = 0x3124 -> DECODE then ADD with ra = 1, rb = 2, w = 4, alu_s = 1, rf_w_wr = 1, then FETCH.
REQ-036 SHALL verify LOAD: im_q = 0x2A53 -> LOAD_A with d_addr = 0xA5, then LOAD_B with rf_s = 1, w = 3, rf_w_wr = 1.
REQ-037 SHALL verify STORE: im_q = 0x1780 -> STORE with ra = 7, d_addr = 0x80, d_wr = 1, rf_w_wr = 0.
REQ-038 SHALL verify JPZ:
- im_q = 0x62FC with ra_zero = 1 -> pc_up = 0xFB (−5).
- Same instruction with ra_zero = 0 -> pc_up = 0.
- Without CTRL_JPZ_EN -> NOOP.
REQ-039 SHALL verify HALT: im_q = 0x5000 -> HALT with halted = 1 for 10 cycles; clr mid-LOAD_A -> INIT with d_wr = 0 and rf_w_wr = 0.
